// File: rtl/game_pkg.sv
// Shared types and constants for the game countdown timer.
// Used by game_countdown_timer and game_bcd_down_counter.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPaused  = 2'd2,
    StExpired = 2'd3
  } game_state_e;

  localparam int unsigned BCD_W          = 4;
  localparam int unsigned MAX_SECONDS    = 99;
  localparam int unsigned WARN_THRESHOLD = 10;

  // Binary seconds to packed {tens, ones}; values above MAX_SECONDS clamp.
  function automatic logic [2*BCD_W-1:0] bin_to_bcd(input logic [6:0] bin);
    logic [6:0] clamped;
    clamped = (bin > 7'(MAX_SECONDS)) ? 7'(MAX_SECONDS) : bin;
    return {BCD_W'(clamped / 7'd10), BCD_W'(clamped % 7'd10)};
  endfunction

  function automatic logic at_or_below_warn(input logic [BCD_W-1:0] tens,
                                            input logic [BCD_W-1:0] ones);
    logic [7:0] value;
    value = 8'(tens) * 8'd10 + 8'(ones);
    return value <= 8'(WARN_THRESHOLD);
  endfunction

endpackage

// File: rtl/game_bcd_down_counter.sv
// Two-digit BCD seconds register with load, saturating decrement and a zero flag.
module game_bcd_down_counter
  import game_pkg::*;
#(
  parameter logic [2*BCD_W-1:0] ResetValue = 8'h60
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_tens_i,
  input  logic [BCD_W-1:0] load_ones_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] tens_o,
  output logic [BCD_W-1:0] ones_o,
  output logic             zero_o
);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;

  assign zero_o = (tens_q == '0) && (ones_q == '0);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load_i) begin
      tens_d = load_tens_i;
      ones_d = load_ones_i;
    end else if (dec_i && !zero_o) begin
      if (ones_q == '0) begin
        ones_d = BCD_W'(9);
        tens_d = tens_q - BCD_W'(1);
      end else begin
        ones_d = ones_q - BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tens_q <= ResetValue[2*BCD_W-1:BCD_W];
      ones_q <= ResetValue[BCD_W-1:0];
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown: edge-detects Clock_division, prescales to seconds, counts down in BCD.
// Optional GAME_TIMER_WARN_EN drives Warning for the last WARN_THRESHOLD seconds.
module game_countdown_timer
  import game_pkg::*;
#(
  parameter int unsigned START_SECONDS = 60,
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Clock_division,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Load,
  input  logic [6:0] Load_value,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Running,
  output logic       Time_up,
  output logic       Expired,
  output logic       Warning
);

  localparam logic [2*BCD_W-1:0] StartBcd  = bin_to_bcd(7'(START_SECONDS));
  localparam logic [7:0]         PrescLast = 8'(TICKS_PER_SEC - 1);

  game_state_e state_q, state_d;
  logic [7:0]  presc_q, presc_d;
  logic        cdiv_q;
  logic        time_up_q, time_up_d;
  logic        running_q;
  logic        expired_q;

  logic               tick;
  logic               cnt_load;
  logic [2*BCD_W-1:0] cnt_load_val;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [BCD_W-1:0]   tens;
  logic [BCD_W-1:0]   ones;
  logic               one_left;

  assign tick     = Clock_division & ~cdiv_q;
  assign one_left = (tens == '0) && (ones == BCD_W'(1));

  game_bcd_down_counter #(
    .ResetValue (StartBcd)
  ) u_counter (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .load_i      (cnt_load),
    .load_tens_i (cnt_load_val[2*BCD_W-1:BCD_W]),
    .load_ones_i (cnt_load_val[BCD_W-1:0]),
    .dec_i       (cnt_dec),
    .tens_o      (tens),
    .ones_o      (ones),
    .zero_o      (cnt_zero)
  );

  // Priority: Load, Pause, Start, tick. Each branch excludes the lower ones.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_load     = 1'b0;
    cnt_load_val = StartBcd;
    cnt_dec      = 1'b0;
    time_up_d    = 1'b0;
    if (Load) begin
      cnt_load     = 1'b1;
      cnt_load_val = bin_to_bcd(Load_value);
      presc_d      = '0;
      state_d      = StIdle;
    end else if (Pause) begin
      if (state_q == StRun) begin
        state_d = StPaused;
      end
    end else if (Start && (state_q != StRun)) begin
      case (state_q)
        StIdle: begin
          if (!cnt_zero) begin
            state_d = StRun;
            presc_d = '0;
          end
        end
        StPaused: state_d = StRun;
        StExpired: begin
          cnt_load = 1'b1;
          presc_d  = '0;
          state_d  = StRun;
        end
        default: ;
      endcase
    end else if ((state_q == StRun) && tick) begin
      if (presc_q == PrescLast) begin
        presc_d = '0;
        cnt_dec = 1'b1;
        if (one_left) begin
          time_up_d = 1'b1;
          state_d   = StExpired;
        end
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      cdiv_q    <= 1'b0;
      time_up_q <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cdiv_q    <= Clock_division;
      time_up_q <= time_up_d;
      running_q <= (state_d == StRun);
      expired_q <= (state_d == StExpired);
    end
  end

  assign Tens    = tens;
  assign Ones    = ones;
  assign Running = running_q;
  assign Time_up = time_up_q;
  assign Expired = expired_q;

`ifdef GAME_TIMER_WARN_EN
  // Decoded from registered state and digits only, so it moves with the digits.
  assign Warning = ((state_q == StRun) || (state_q == StPaused)) && at_or_below_warn(tens, ones);
`else
  assign Warning = 1'b0;
`endif

endmodule
